// File: rtl/wavegen_sweep_ctrl.sv
// wavegen_sweep_ctrl: per-channel frequency-sweep scheduler feeding wavegen_n_channel.
// Optional macro WAVEGEN_SWEEP_LOOP_EN adds a per-channel loop (sawtooth) bit at cfg_addr 3, bit DW.
module wavegen_sweep_ctrl #(
    parameter  int CH = 4,
    parameter  int PW = 16,
    parameter  int DW = 16,
    localparam int CW = $clog2(CH),
`ifdef WAVEGEN_SWEEP_LOOP_EN
    localparam int XW = (PW > DW + 1) ? PW : DW + 1
`else
    localparam int XW = (PW > DW) ? PW : DW
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [1:0]    cfg_addr,
    input  logic [XW-1:0] cfg_data,
    input  logic [CH-1:0] ch_start,
    input  logic [CH-1:0] ch_stop,
    output logic [PW-1:0] step_size [CH],
    output logic [CH-1:0] channel_en,
    output logic [CH-1:0] sweep_done,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state     [CH];
    logic [PW-1:0] cfg_start [CH];
    logic [PW-1:0] cfg_stop  [CH];
    logic [PW-1:0] cfg_incr  [CH];
    logic [DW-1:0] cfg_dwell [CH];
    logic [DW-1:0] dwell_cnt [CH];
    logic [PW-1:0] nxt_step  [CH];
    logic [CH-1:0] pending;
    logic [CH-1:0] dir_up;
    logic [CH-1:0] loop_on;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] gnt_idx;
    logic          gnt_vld;

    // A dwell of 0 behaves like 1 so a step never lands on back-to-back cycles.
    function automatic logic [DW-1:0] dwell_load(input logic [DW-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    // Saturating step toward stop; the extra sum bit keeps up-ramps from wrapping.
    // A looping channel sitting at stop restarts from start on its next update.
    function automatic logic [PW-1:0] step_next(
        input logic [PW-1:0] cur,
        input logic [PW-1:0] start,
        input logic [PW-1:0] stop,
        input logic [PW-1:0] incr,
        input logic          up,
        input logic          wrap
    );
        logic [PW:0] sum;
        sum = {1'b0, cur} + {1'b0, incr};
        if (wrap && cur == stop) return start;
        if (up) return (sum >= {1'b0, stop}) ? stop : sum[PW-1:0];
        if ({1'b0, cur} <= {1'b0, stop} + {1'b0, incr}) return stop;
        return cur - incr;
    endfunction

    assign cfg_ready = (state[cfg_ch] != S_RUN);

`ifdef WAVEGEN_SWEEP_LOOP_EN
    logic [CH-1:0] cfg_loop;
    assign loop_on = cfg_loop;
`else
    assign loop_on = '0;
`endif

    // Config register file, written only while the target channel is not running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                cfg_start[i] <= '0;
                cfg_stop[i]  <= '0;
                cfg_incr[i]  <= '0;
                cfg_dwell[i] <= '0;
            end
`ifdef WAVEGEN_SWEEP_LOOP_EN
            cfg_loop <= '0;
`endif
        end else if (cfg_valid && cfg_ready) begin
            unique case (cfg_addr)
                2'd0: cfg_start[cfg_ch] <= cfg_data[PW-1:0];
                2'd1: cfg_stop[cfg_ch]  <= cfg_data[PW-1:0];
                2'd2: cfg_incr[cfg_ch]  <= cfg_data[PW-1:0];
                2'd3: begin
                    cfg_dwell[cfg_ch] <= cfg_data[DW-1:0];
`ifdef WAVEGEN_SWEEP_LOOP_EN
                    cfg_loop[cfg_ch]  <= cfg_data[DW];
`endif
                end
            endcase
        end
    end

    // Shared add/compare datapath, evaluated for every channel; only the granted one is used.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            nxt_step[i] = step_next(step_size[i], cfg_start[i], cfg_stop[i],
                                    cfg_incr[i], dir_up[i], loop_on[i]);
        end
    end

    // Round-robin search for one pending channel, starting just after the last grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = 1; k <= CH; k++) begin
            if (!gnt_vld && pending[(int'(rr_ptr) + k) % CH]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'((int'(rr_ptr) + k) % CH);
            end
        end
    end

    // busy reflects any channel still ramping.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (state[i] == S_RUN) busy = 1'b1;
        end
    end

    // Per-channel FSMs; stop beats start beats grant, and a discarded grant keeps the pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                state[i]     <= S_IDLE;
                step_size[i] <= '0;
                dwell_cnt[i] <= '0;
            end
            channel_en <= '0;
            sweep_done <= '0;
            pending    <= '0;
            dir_up     <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                sweep_done[i] <= 1'b0;
                if (ch_stop[i]) begin
                    state[i]      <= S_IDLE;
                    channel_en[i] <= 1'b0;
                    pending[i]    <= 1'b0;
                end else if (ch_start[i] && state[i] != S_RUN) begin
                    step_size[i]  <= cfg_start[i];
                    channel_en[i] <= 1'b1;
                    dwell_cnt[i]  <= dwell_load(cfg_dwell[i]);
                    pending[i]    <= 1'b0;
                    dir_up[i]     <= (cfg_start[i] < cfg_stop[i]);
                    if (cfg_start[i] == cfg_stop[i]) begin
                        state[i]      <= S_DONE;
                        sweep_done[i] <= 1'b1;
                    end else begin
                        state[i] <= S_RUN;
                    end
                end else if (gnt_vld && gnt_idx == CW'(i)) begin
                    step_size[i] <= nxt_step[i];
                    pending[i]   <= 1'b0;
                    dwell_cnt[i] <= dwell_load(cfg_dwell[i]);
                    if (nxt_step[i] == cfg_stop[i]) begin
                        sweep_done[i] <= 1'b1;
                        if (!loop_on[i]) state[i] <= S_DONE;
                    end
                end else if (state[i] == S_RUN && !pending[i]) begin
                    if (dwell_cnt[i] == '0) pending[i] <= 1'b1;
                    else dwell_cnt[i] <= dwell_cnt[i] - 1'b1;
                end
            end
            if (gnt_vld && !ch_stop[gnt_idx]) rr_ptr <= gnt_idx;
        end
    end

endmodule
